// File: rtl/reel_sequencer.sv
// rtl/reel_sequencer.sv - three-reel spin sequencer with staggered stops, win flash and credit latches
// Optional CREDIT_GATE_EN: refuse spins while the latched credit balance is zero.
module reel_sequencer #(
    parameter int STEP_CYCLES    = 1000000,
    parameter int NUM_SYMBOLS    = 10,
    parameter int MIN_SPIN_STEPS = 24,
    parameter int STAGGER_STEPS  = 8,
    parameter int FLASH_STEPS    = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  reel1_idx,
    input  logic [3:0]  reel2_idx,
    input  logic [3:0]  reel3_idx,
    input  logic        start_spin,
    input  logic [11:0] win_credits,
    input  logic        is_win,
    input  logic [11:0] total_credits,
    input  logic        is_total,
    output logic [3:0]  reel1_pos,
    output logic [3:0]  reel2_pos,
    output logic [3:0]  reel3_pos,
    output logic [2:0]  reel_moving,
    output logic        busy,
    output logic        spin_done,
    output logic        win_lamp,
    output logic [11:0] win_display,
    output logic [11:0] credit_display
);

    localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int CW = 16;
    localparam logic [PW-1:0] PRESC_LAST = PW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0] MIN_C      = CW'(MIN_SPIN_STEPS);
    localparam logic [CW-1:0] STAG_C     = CW'(STAGGER_STEPS);
    localparam logic [CW-1:0] FLASH_LAST = CW'(FLASH_STEPS - 1);
    localparam logic [3:0]    SYM_LAST   = 4'(NUM_SYMBOLS - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SPIN   = 2'd1;
    localparam logic [1:0] S_RESULT = 2'd2;
    localparam logic [1:0] S_FLASH  = 2'd3;

    logic [1:0]       state;
    logic [PW-1:0]    presc;
    logic [CW-1:0]    step_cnt;
    logic [CW-1:0]    stop1;
    logic [CW-1:0]    stop2;
    logic [2:0][3:0]  pos_q;
    logic [2:0][3:0]  tgt_q;
    logic [2:0][3:0]  pos_adv;
    logic [2:0][3:0]  tgt_clip;
    logic [2:0]       stop_now;
    logic [CW-1:0]    n_next;
    logic             tick;
    logic             accept;
    logic             gate_ok;

`ifdef CREDIT_GATE_EN
    assign gate_ok = (credit_display != 12'd0);
`else
    assign gate_ok = 1'b1;
`endif

    assign tick   = ((state == S_SPIN) || (state == S_FLASH)) && (presc == PRESC_LAST);
    assign accept = (state == S_IDLE) && start_spin && gate_ok;
    assign n_next = step_cnt + CW'(1);

    assign reel1_pos = pos_q[0];
    assign reel2_pos = pos_q[1];
    assign reel3_pos = pos_q[2];
    assign busy      = (state != S_IDLE);
    assign spin_done = (state == S_RESULT);

    always_comb begin
        tgt_clip[0] = (32'(reel1_idx) >= NUM_SYMBOLS) ? 4'd0 : reel1_idx;
        tgt_clip[1] = (32'(reel2_idx) >= NUM_SYMBOLS) ? 4'd0 : reel2_idx;
        tgt_clip[2] = (32'(reel3_idx) >= NUM_SYMBOLS) ? 4'd0 : reel3_idx;
        for (int k = 0; k < 3; k++) begin
            pos_adv[k] = (pos_q[k] == SYM_LAST) ? 4'd0 : pos_q[k] + 4'd1;
        end
        // A later reel may only stop once its predecessor has already stopped on an earlier tick.
        stop_now[0] = reel_moving[0] && (n_next >= MIN_C) && (pos_adv[0] == tgt_q[0]);
        stop_now[1] = reel_moving[1] && !reel_moving[0] && (n_next >= stop1 + STAG_C)
                      && (pos_adv[1] == tgt_q[1]);
        stop_now[2] = reel_moving[2] && !reel_moving[1] && (n_next >= stop2 + STAG_C)
                      && (pos_adv[2] == tgt_q[2]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            presc          <= '0;
            step_cnt       <= '0;
            stop1          <= '0;
            stop2          <= '0;
            pos_q          <= '0;
            tgt_q          <= '0;
            reel_moving    <= 3'b000;
            win_lamp       <= 1'b0;
            win_display    <= 12'd0;
            credit_display <= 12'd0;
        end else begin
            if ((state == S_SPIN) || (state == S_FLASH)) begin
                presc <= tick ? '0 : presc + PW'(1);
            end else begin
                presc <= '0;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        tgt_q       <= tgt_clip;
                        step_cnt    <= '0;
                        reel_moving <= 3'b111;
                        state       <= S_SPIN;
                    end
                end
                S_SPIN: begin
                    if (tick) begin
                        step_cnt <= n_next;
                        for (int k = 0; k < 3; k++) begin
                            if (reel_moving[k]) pos_q[k] <= pos_adv[k];
                        end
                        reel_moving <= reel_moving & ~stop_now;
                        if (stop_now[0]) stop1 <= n_next;
                        if (stop_now[1]) stop2 <= n_next;
                        if (stop_now[2]) state <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    step_cnt <= '0;
                    win_lamp <= 1'b0;
                    state    <= (win_display != 12'd0) ? S_FLASH : S_IDLE;
                end
                default: begin
                    if (tick) begin
                        if (step_cnt == FLASH_LAST) begin
                            win_lamp <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            win_lamp <= ~win_lamp;
                            step_cnt <= n_next;
                        end
                    end
                end
            endcase

            // A simultaneous win report takes priority over the clear on spin start.
            if (is_win) begin
                win_display <= win_credits;
            end else if (accept) begin
                win_display <= 12'd0;
            end
            if (is_total) credit_display <= total_credits;
        end
    end

endmodule
